b1_acq_corr: RTL and testbench

Parametrised B1 pilot acquisition/tracking correlator front end. It wipes off the carrier with an internal carrier NCO and forms Early/Prompt/Late replicas from an externally generated TMBOC chip stream, with configurable E-L spacing. It integrates I/Q × E/P/L over N code periods and hands six correlation sums to the loop processor over a valid/ack handshake. It sits between the ADC sample path and the tracking-loop software, and replaces the fixed-spacing, non-integrating acquisition front end.

---
 rtl/b1_acq_corr.sv | 209 ++++++++++++++++++++
 tb/tb_b1_acq_corr.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/b1_acq_corr.sv
// B1 pilot correlator front end: carrier wipe-off, E/P/L replica taps and N-period I/Q integration.
// Build option: define B1ACQ_SAT_EN for saturating accumulators (default wraps).

module b1_acq_corr_acc #(
  parameter int unsigned PW = 10,
  parameter int unsigned IW = 24
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic signed [PW-1:0] prod_i,
  input  logic                 neg_i,
  input  logic                 load_i,
  output logic signed [IW-1:0] acc_o
);
  logic signed [IW:0]   addend, base, sum;
  logic signed [IW-1:0] acc_d, acc_q;

  always_comb begin
    addend = (IW+1)'(prod_i);
    if (neg_i) addend = -addend;
    base = load_i ? '0 : (IW+1)'(acc_q);
    sum  = base + addend;
`ifdef B1ACQ_SAT_EN
    if (sum[IW] != sum[IW-1])
      acc_d = sum[IW] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
    else
      acc_d = sum[IW-1:0];
`else
    acc_d = sum[IW-1:0];
`endif
  end

`ifndef B1ACQ_SAT_EN
  logic unused_msb;
  assign unused_msb = sum[IW];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

module b1_acq_corr #(
  parameter int unsigned          SRC_WIDTH = 8,
  parameter int unsigned          ACC_WIDTH = 32,
  parameter logic [ACC_WIDTH-1:0] CAR_BIAS  = 32'd1975684956,
  parameter logic [ACC_WIDTH-1:0] PRN_BIAS  = 32'd228246833,
  parameter int unsigned          SPACING   = 1,
  parameter int unsigned          NCOH      = 1,
  parameter int unsigned          INT_WIDTH = 24
) (
  input  logic                        rx_clk,
  input  logic                        rx_rst,
  input  logic signed [SRC_WIDTH-1:0] rx_src,
  input  logic [ACC_WIDTH-1:0]        rx_car_fcw,
  input  logic [ACC_WIDTH-1:0]        rx_prn_fcw,
  input  logic                        rx_loc_code,
  input  logic                        rx_phs_tick,
  input  logic                        rx_prn_sop,
  input  logic                        rx_corr_ack,
  output logic [ACC_WIDTH-1:0]        tx_prn_fcw,
  output logic [ACC_WIDTH-1:0]        tx_car_nco,
  output logic                        tx_loc_E,
  output logic                        tx_loc_P,
  output logic                        tx_loc_L,
  output logic signed [INT_WIDTH-1:0] tx_ie,
  output logic signed [INT_WIDTH-1:0] tx_qe,
  output logic signed [INT_WIDTH-1:0] tx_ip,
  output logic signed [INT_WIDTH-1:0] tx_qp,
  output logic signed [INT_WIDTH-1:0] tx_il,
  output logic signed [INT_WIDTH-1:0] tx_ql,
  output logic                        tx_corr_valid,
  output logic                        tx_corr_ovf,
  output logic [15:0]                 tx_dump_cnt
);
  localparam int unsigned PW   = SRC_WIDTH + 2;
  localparam int unsigned TAPS = 2*SPACING + 1;
  localparam logic [9:0]  LAST = 10'(NCOH - 1);

  logic [ACC_WIDTH-1:0] car_fcw, car_nco_q, car_nco_d;
  logic [TAPS-1:0]      line_q;

  // stage 0: sample, phase index and pre-shift taps
  logic signed [SRC_WIDTH-1:0] src_q;
  logic [2:0]                  k_q, tap_q;
  logic                        sop_q;
  // stage 1: mixer products aligned with their taps/sop
  logic signed [PW-1:0]        i_q, q_q, i_d, q_d, sx;
  logic [2:0]                  tap2_q;
  logic                        sop2_q;

  logic [9:0]                  per_q;
  logic                        started_q, valid_q, ovf_q;
  logic [15:0]                 cnt_q;
  logic [5:0][INT_WIDTH-1:0]   acc, res_q;
  logic                        dump, load;
  logic [1:0]                  cos_c, sin_c;

  assign car_fcw    = CAR_BIAS - rx_car_fcw;
  assign car_nco_d  = car_nco_q + car_fcw;
  assign tx_prn_fcw = {rx_prn_fcw[ACC_WIDTH-3:0], 2'b00} + PRN_BIAS;
  assign tx_car_nco = car_nco_q;

  logic unused_fcw;
  assign unused_fcw = ^rx_prn_fcw[ACC_WIDTH-1 -: 2];

  assign tx_loc_E = line_q[0];
  assign tx_loc_P = line_q[SPACING];
  assign tx_loc_L = line_q[2*SPACING];

  // LUT entries coded as {negate, double}
  function automatic logic signed [PW-1:0] scale(input logic signed [PW-1:0] x,
                                                 input logic [1:0] c);
    logic signed [PW-1:0] m;
    m = c[0] ? (x <<< 1) : x;
    return c[1] ? -m : m;
  endfunction

  always_comb begin
    cos_c = 2'b00;
    sin_c = 2'b00;
    case (k_q)
      3'd0: begin cos_c = 2'b01; sin_c = 2'b00; end
      3'd1: begin cos_c = 2'b00; sin_c = 2'b01; end
      3'd2: begin cos_c = 2'b10; sin_c = 2'b01; end
      3'd3: begin cos_c = 2'b11; sin_c = 2'b00; end
      3'd4: begin cos_c = 2'b11; sin_c = 2'b10; end
      3'd5: begin cos_c = 2'b10; sin_c = 2'b11; end
      3'd6: begin cos_c = 2'b00; sin_c = 2'b11; end
      default: begin cos_c = 2'b01; sin_c = 2'b10; end
    endcase
  end

  assign sx  = PW'(src_q);
  assign i_d = scale(sx, cos_c);
  assign q_d = scale(sx, sin_c);

  // a wrapping sop dumps; the first sop after reset only restarts integration
  assign dump = sop2_q && started_q && (per_q == LAST);
  assign load = sop2_q && (!started_q || dump);

  for (genvar l = 0; l < 6; l++) begin : g_lane
    b1_acq_corr_acc #(.PW(PW), .IW(INT_WIDTH)) u_acc (
      .clk_i  (rx_clk),
      .rst_i  (rx_rst),
      .prod_i ((l % 2 == 0) ? i_q : q_q),
      .neg_i  (~tap2_q[l/2]),
      .load_i (load),
      .acc_o  (acc[l])
    );
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      car_nco_q <= '0;
      line_q    <= '0;
      src_q     <= '0;
      k_q       <= '0;
      tap_q     <= '0;
      sop_q     <= 1'b0;
      i_q       <= '0;
      q_q       <= '0;
      tap2_q    <= '0;
      sop2_q    <= 1'b0;
      per_q     <= '0;
      started_q <= 1'b0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      res_q     <= '0;
    end else begin
      car_nco_q <= car_nco_d;
      src_q     <= rx_src;
      k_q       <= car_nco_q[ACC_WIDTH-1 -: 3];
      sop_q     <= rx_prn_sop;
      tap_q     <= {tx_loc_L, tx_loc_P, tx_loc_E};
      if (rx_phs_tick) line_q <= {line_q[TAPS-2:0], rx_loc_code};
      i_q       <= i_d;
      q_q       <= q_d;
      sop2_q    <= sop_q;
      tap2_q    <= tap_q;
      if (sop2_q) begin
        started_q <= 1'b1;
        per_q     <= load ? 10'd0 : per_q + 10'd1;
      end
      if (dump) begin
        res_q   <= acc;
        valid_q <= 1'b1;
        cnt_q   <= cnt_q + 16'd1;
        if (valid_q && !rx_corr_ack) ovf_q <= 1'b1;
      end else if (rx_corr_ack) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign tx_ie         = res_q[0];
  assign tx_qe         = res_q[1];
  assign tx_ip         = res_q[2];
  assign tx_qp         = res_q[3];
  assign tx_il         = res_q[4];
  assign tx_ql         = res_q[5];
  assign tx_corr_valid = valid_q;
  assign tx_corr_ovf   = ovf_q;
  assign tx_dump_cnt   = cnt_q;
endmodule

// File: tb/tb_b1_acq_corr.sv
// Randomized bench for b1_acq_corr against a sample-level correlation model.
module tb_b1_acq_corr;
  localparam int SW = 8, AW = 32, SP = 2, NC = 3, IW = 12;
  localparam logic [31:0] CB = 32'd1975684956;
  localparam logic [31:0] PB = 32'd228246833;

  logic                 rx_clk, rx_rst;
  logic signed [SW-1:0] rx_src;
  logic [AW-1:0]        rx_car_fcw, rx_prn_fcw;
  logic                 rx_loc_code, rx_phs_tick, rx_prn_sop, rx_corr_ack;
  logic [AW-1:0]        tx_prn_fcw, tx_car_nco;
  logic                 tx_loc_E, tx_loc_P, tx_loc_L;
  logic signed [IW-1:0] tx_ie, tx_qe, tx_ip, tx_qp, tx_il, tx_ql;
  logic                 tx_corr_valid, tx_corr_ovf;
  logic [15:0]          tx_dump_cnt;

  b1_acq_corr #(.SRC_WIDTH(SW), .ACC_WIDTH(AW), .CAR_BIAS(CB), .PRN_BIAS(PB),
                .SPACING(SP), .NCOH(NC), .INT_WIDTH(IW)) dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .rx_src(rx_src), .rx_car_fcw(rx_car_fcw),
    .rx_prn_fcw(rx_prn_fcw), .rx_loc_code(rx_loc_code), .rx_phs_tick(rx_phs_tick),
    .rx_prn_sop(rx_prn_sop), .rx_corr_ack(rx_corr_ack), .tx_prn_fcw(tx_prn_fcw),
    .tx_car_nco(tx_car_nco), .tx_loc_E(tx_loc_E), .tx_loc_P(tx_loc_P), .tx_loc_L(tx_loc_L),
    .tx_ie(tx_ie), .tx_qe(tx_qe), .tx_ip(tx_ip), .tx_qp(tx_qp), .tx_il(tx_il), .tx_ql(tx_ql),
    .tx_corr_valid(tx_corr_valid), .tx_corr_ovf(tx_corr_ovf), .tx_dump_cnt(tx_dump_cnt));

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  int n_cmp, n_bad;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // reference model: per-sample records, tap history and integer sums
  typedef struct { int i; int q; bit e; bit p; bit l; bit sop; } rec_t;
  rec_t        pq[$];
  bit          hist[$];
  logic [31:0] m_nco;
  int          m_acc[6], m_res[6];
  bit          m_started, m_vld, m_ovf;
  int          m_per, m_cnt;
  int          COS[8] = '{2, 1, -1, -2, -2, -1, 1, 2};
  int          SIN[8] = '{1, 2, 2, 1, -1, -2, -2, -1};

  function automatic int fit(input int s);
`ifdef B1ACQ_SAT_EN
    if (s > 2**(IW-1) - 1) return 2**(IW-1) - 1;
    if (s < -(2**(IW-1)))  return -(2**(IW-1));
    return s;
`else
    int u;
    u = s & (2**IW - 1);
    if (u >= 2**(IW-1)) u -= 2**IW;
    return u;
`endif
  endfunction

  task automatic model_reset();
    pq.delete();
    hist.delete();
    for (int j = 0; j < 2*SP+1; j++) hist.push_back(1'b0);
    m_nco = '0;
    for (int j = 0; j < 6; j++) begin m_acc[j] = 0; m_res[j] = 0; end
    m_started = 0; m_vld = 0; m_ovf = 0; m_per = 0; m_cnt = 0;
  endtask

  task automatic model_proc(input rec_t r, input bit ack);
    int  c[6];
    bit  dump, restart;
    c[0] = r.e ? r.i : -r.i;  c[1] = r.e ? r.q : -r.q;
    c[2] = r.p ? r.i : -r.i;  c[3] = r.p ? r.q : -r.q;
    c[4] = r.l ? r.i : -r.i;  c[5] = r.l ? r.q : -r.q;
    dump    = r.sop && m_started && (m_per == NC - 1);
    restart = r.sop && (!m_started || dump);
    if (dump) begin
      m_res = m_acc;
      if (m_vld && !ack) m_ovf = 1;
      m_vld = 1;
      m_cnt = (m_cnt + 1) % 65536;
    end else if (ack) m_vld = 0;
    for (int j = 0; j < 6; j++) m_acc[j] = restart ? fit(c[j]) : fit(m_acc[j] + c[j]);
    if (r.sop) begin
      m_per = restart ? 0 : m_per + 1;
      m_started = 1;
    end
  endtask

  task automatic compare_all();
    logic [31:0] pf;
    pf = rx_prn_fcw * 32'd4 + PB;
    chk("car_nco", tx_car_nco, m_nco);
    chk("prn_fcw", tx_prn_fcw, pf);
    chk("loc_E", tx_loc_E, hist[0]);
    chk("loc_P", tx_loc_P, hist[SP]);
    chk("loc_L", tx_loc_L, hist[2*SP]);
    chk("valid", tx_corr_valid, m_vld);
    chk("ovf", tx_corr_ovf, m_ovf);
    chk("dump_cnt", tx_dump_cnt, m_cnt);
    if (m_vld) begin
      chk("ie", tx_ie, m_res[0]); chk("qe", tx_qe, m_res[1]);
      chk("ip", tx_ip, m_res[2]); chk("qp", tx_qp, m_res[3]);
      chk("il", tx_il, m_res[4]); chk("ql", tx_ql, m_res[5]);
    end
  endtask

  task automatic run_cycle(input logic [7:0] src, input logic [31:0] cf, input bit code,
                           input bit tick, input bit sop, input bit ack);
    rec_t r;
    int   k;
    rx_src = src; rx_car_fcw = cf; rx_loc_code = code;
    rx_phs_tick = tick; rx_prn_sop = sop; rx_corr_ack = ack;
    k     = int'(m_nco[31:29]);
    r.i   = $signed(src) * COS[k];
    r.q   = $signed(src) * SIN[k];
    r.e   = hist[0]; r.p = hist[SP]; r.l = hist[2*SP];
    r.sop = sop;
    pq.push_back(r);
    if (pq.size() > 2) model_proc(pq.pop_front(), ack);
    m_nco = m_nco + (CB - cf);
    if (tick) begin
      hist.push_front(code);
      void'(hist.pop_back());
    end
    @(posedge rx_clk); #1;
    compare_all();
  endtask

  task automatic do_reset();
    rx_rst = 1'b1;
    rx_src = '0; rx_car_fcw = '0; rx_loc_code = 0;
    rx_phs_tick = 0; rx_prn_sop = 0; rx_corr_ack = 0;
    repeat (3) @(posedge rx_clk);
    #1;
    chk("rst_nco", tx_car_nco, 0);
    chk("rst_valid", tx_corr_valid, 0);
    chk("rst_ovf", tx_corr_ovf, 0);
    chk("rst_cnt", tx_dump_cnt, 0);
    chk("rst_taps", {tx_loc_E, tx_loc_P, tx_loc_L}, 0);
    chk("rst_ip", tx_ip, 0);
    rx_rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [63:0] t;
    int          cd;
    bit          sop;
    n_cmp = 0; n_bad = 0;
    rx_prn_fcw = 32'd1;
    do_reset();

    // free-running NCO with no Doppler
    for (int c = 0; c < 50; c++) run_cycle(8'd0, 32'd0, 0, 0, 0, 0);
    t = 64'd50 * 64'(CB);
    chk("nco_50", tx_car_nco, t[31:0]);
    chk("prn_fcw_1", tx_prn_fcw, 32'd228246837);

    // random traffic, with a reset in the middle
    cd = 3;
    for (int c = 0; c < 2400; c++) begin
      if (c == 1200) do_reset();
      if ((c % 200) == 0) rx_prn_fcw = $urandom;
      sop = (cd == 0);
      cd  = sop ? $urandom_range(4, 25) : cd - 1;
      run_cycle(8'($urandom), $urandom, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0), sop,
                (c < 1200) ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 3) == 0));
    end

    // k held at 0, full-scale input over 90-sample windows, no ack -> overflow
    do_reset();
    for (int c = 0; c < 200; c++)
      run_cycle(8'd127, CB, 1, (c < 6), (c >= 10 && c <= 190 && ((c - 10) % 30) == 0), 0);
    chk("ovf_set", tx_corr_ovf, 1);
    chk("ovf_cnt", tx_dump_cnt, 2);
`ifdef B1ACQ_SAT_EN
    chk("sat_ip", tx_ip, 2047);
`else
    chk("wrap_ip", tx_ip, -1716);
`endif
    run_cycle(8'd127, CB, 1, 0, 0, 1);
    chk("ack_clr", tx_corr_valid, 0);

    // ack landing exactly on dump edges
    do_reset();
    for (int c = 0; c < 70; c++)
      run_cycle(8'($urandom), $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 0),
                (c % 10) == 0 && c <= 60, (c == 32 || c == 62));
    chk("coinc_valid", tx_corr_valid, 1);
    chk("coinc_ovf", tx_corr_ovf, 0);
    chk("coinc_cnt", tx_dump_cnt, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
